// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson code decoder.
package johnson_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } lock_state_e;

    function automatic int index_width(input int n);
        return (n < 1) ? 1 : $clog2(2 * n);
    endfunction

endpackage

// File: rtl/johnson_code_check.sv
// Combinational Johnson code validator: legal flag and ring position of an N-bit code.
module johnson_code_check
    import johnson_pkg::*;
#(
    parameter int N  = 8,
    parameter int IW = index_width(N)
) (
    input  logic [N-1:0]  code,
    output logic          legal,
    output logic [IW-1:0] index
);

    logic [IW-1:0] edges;
    logic [IW-1:0] pop;
    logic [IW:0]   diff;

    always_comb begin
        edges = '0;
        pop   = '0;
        diff  = '0;
        for (int i = 0; i < N - 1; i++) begin
            edges = edges + IW'(code[i] ^ code[i+1]);
        end
        for (int i = 0; i < N; i++) begin
            pop = pop + IW'(code[i]);
        end
        // Any code with at most one bit transition is one of the 2N ring states
        legal = (edges <= IW'(1));
        if (code[N-1] || (code == '0)) begin
            index = pop;
        end else begin
            diff  = (IW + 1)'(2 * N) - {1'b0, pop};
            index = diff[IW-1:0];
        end
    end

endmodule

// File: rtl/johnson_decoder.sv
// Johnson code decoder with lock tracking, sticky error flags and ring wrap counter.
module johnson_decoder
    import johnson_pkg::*;
#(
    parameter int N        = 8,
    parameter int LOCK_LEN = 4,
    parameter int WRAP_W   = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [N-1:0]             code,
    input  logic                     clear_err,
    output logic                     out_valid,
    output logic [$clog2(2*N)-1:0]   index,
    output logic [2*N-1:0]           onehot,
    output logic                     locked,
    output logic                     code_err,
    output logic                     seq_err,
    output logic [WRAP_W-1:0]        wrap_cnt
);

    localparam int RING = 2 * N;
    localparam int IW   = index_width(N);
    localparam int RW   = $clog2(RING + 1);

    logic          legal_c;
    logic [IW-1:0] idx_c;
    logic [IW-1:0] succ_c;

    lock_state_e   state_q, state_d;
    logic [RW-1:0] run_q, run_d;
    logic [IW-1:0] prev_q, prev_d;
    logic          prev_vld_q, prev_vld_d;
    logic [IW-1:0] index_q, index_d;
    logic [RING-1:0] onehot_q, onehot_d;
    logic          out_valid_q, out_valid_d;
    logic          locked_q, locked_d;
    logic          code_err_q, code_err_d;
    logic          seq_err_q, seq_err_d;
    logic [WRAP_W-1:0] wrap_cnt_q, wrap_cnt_d;

    johnson_code_check #(.N(N), .IW(IW)) u_check (
        .code  (code),
        .legal (legal_c),
        .index (idx_c)
    );

    assign succ_c = (prev_q == IW'(RING - 1)) ? '0 : prev_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        run_d       = run_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        index_d     = index_q;
        onehot_d    = onehot_q;
        wrap_cnt_d  = wrap_cnt_q;
        code_err_d  = code_err_q & ~clear_err;
        seq_err_d   = seq_err_q & ~clear_err;
        out_valid_d = in_valid & legal_c;

        if (in_valid) begin
            if (!legal_c) begin
                code_err_d = 1'b1;
                state_d    = SEARCH;
                run_d      = '0;
                prev_vld_d = 1'b0;
            end else begin
                index_d  = idx_c;
                onehot_d = {{(RING-1){1'b0}}, 1'b1} << idx_c;
                if (state_q == SEARCH) begin
                    if (!prev_vld_q) begin
                        prev_d     = idx_c;
                        prev_vld_d = 1'b1;
                        run_d      = RW'(1);
                    end else if (idx_c == succ_c) begin
                        prev_d = idx_c;
                        run_d  = run_q + 1'b1;
                    end else if (idx_c != prev_q) begin
                        prev_d = idx_c;
                        run_d  = RW'(1);
                    end
                    if (run_d >= RW'(LOCK_LEN)) begin
                        state_d = LOCKED;
                    end
                end else begin
                    if (idx_c == succ_c) begin
                        prev_d = idx_c;
                        if (prev_q == IW'(RING - 1)) begin
                            wrap_cnt_d = wrap_cnt_q + 1'b1;
                        end
                    end else if (idx_c == prev_q) begin
                        prev_d = prev_q;
                    end else if (idx_c == '0) begin
                        // Upstream counter was reset: follow it without flagging
                        prev_d = '0;
                    end else begin
                        seq_err_d = 1'b1;
                        state_d   = SEARCH;
                        run_d     = RW'(1);
                        prev_d    = idx_c;
                    end
                end
            end
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SEARCH;
            run_q       <= '0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            index_q     <= '0;
            onehot_q    <= {{(RING-1){1'b0}}, 1'b1};
            out_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            code_err_q  <= 1'b0;
            seq_err_q   <= 1'b0;
            wrap_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            index_q     <= index_d;
            onehot_q    <= onehot_d;
            out_valid_q <= out_valid_d;
            locked_q    <= locked_d;
            code_err_q  <= code_err_d;
            seq_err_q   <= seq_err_d;
            wrap_cnt_q  <= wrap_cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign index     = index_q;
    assign onehot    = onehot_q;
    assign locked    = locked_q;
    assign code_err  = code_err_q;
    assign seq_err   = seq_err_q;
    assign wrap_cnt  = wrap_cnt_q;

endmodule

// File: tb/tb_johnson_decoder.sv
// Directed and randomized bench for johnson_decoder against a table-driven reference model.
module tb_johnson_decoder;

    localparam int N        = 8;
    localparam int LOCK_LEN = 4;
    localparam int WRAP_W   = 8;
    localparam int R        = 2 * N;
    localparam int IW       = $clog2(R);

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0;
    logic [N-1:0]      code = '0;
    logic              clear_err = 1'b0;
    logic              out_valid;
    logic [IW-1:0]     index;
    logic [R-1:0]      onehot;
    logic              locked;
    logic              code_err;
    logic              seq_err;
    logic [WRAP_W-1:0] wrap_cnt;

    int tests = 0;
    int fails = 0;

    int ring [R];
    int m_idx, m_prev, m_run, m_wrap;
    bit m_locked, m_ce, m_se, m_ov;
    int cur;

    johnson_decoder #(.N(N), .LOCK_LEN(LOCK_LEN), .WRAP_W(WRAP_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .code      (code),
        .clear_err (clear_err),
        .out_valid (out_valid),
        .index     (index),
        .onehot    (onehot),
        .locked    (locked),
        .code_err  (code_err),
        .seq_err   (seq_err),
        .wrap_cnt  (wrap_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic int lookup(input int c);
        for (int k = 0; k < R; k++) begin
            if (ring[k] == c) return k;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_idx = 0; m_prev = -1; m_run = 0; m_wrap = 0;
        m_locked = 0; m_ce = 0; m_se = 0; m_ov = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit clr);
        int k;
        k    = lookup(c);
        m_ce = m_ce & ~clr;
        m_se = m_se & ~clr;
        m_ov = v && (k >= 0);
        if (v) begin
            if (k < 0) begin
                m_ce = 1; m_locked = 0; m_run = 0; m_prev = -1;
            end else begin
                m_idx = k;
                if (!m_locked) begin
                    if (m_prev < 0) begin
                        m_prev = k; m_run = 1;
                    end else if (k == (m_prev + 1) % R) begin
                        m_prev = k; m_run++;
                    end else if (k != m_prev) begin
                        m_prev = k; m_run = 1;
                    end
                    if (m_run >= LOCK_LEN) m_locked = 1;
                end else begin
                    if (k == (m_prev + 1) % R) begin
                        if (m_prev == R - 1) m_wrap = (m_wrap + 1) % (1 << WRAP_W);
                        m_prev = k;
                    end else if (k == m_prev) begin
                        m_prev = k;
                    end else if (k == 0) begin
                        m_prev = 0;
                    end else begin
                        m_se = 1; m_locked = 0; m_run = 1; m_prev = k;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        tests++;
        assert (obs === req) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, req);
        end
    endtask

    task automatic check_all(input string w);
        chk({w, ".out_valid"}, 32'(out_valid), 32'(m_ov));
        chk({w, ".index"},     32'(index),     32'(m_idx));
        chk({w, ".onehot"},    32'(onehot),    32'(1) << m_idx);
        chk({w, ".locked"},    32'(locked),    32'(m_locked));
        chk({w, ".code_err"},  32'(code_err),  32'(m_ce));
        chk({w, ".seq_err"},   32'(seq_err),   32'(m_se));
        chk({w, ".wrap_cnt"},  32'(wrap_cnt),  32'(m_wrap));
    endtask

    task automatic step(input string w, input bit v, input int c, input bit clr);
        in_valid  = v;
        code      = N'(c);
        clear_err = clr;
        model_step(v, c, clr);
        @(posedge clk);
        #1;
        check_all(w);
    endtask

    initial begin
        for (int k = 0; k < R; k++) begin
            if (k <= N) ring[k] = ((1 << k) - 1) << (N - k);
            else        ring[k] = (1 << (R - k)) - 1;
        end
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        step("rst", 0, 0, 0);
        chk("rst.onehot_const", 32'(onehot), 32'h0001);

        step("acq0", 1, 'h00, 0);
        step("acq1", 1, 'h80, 0);
        step("acq2", 1, 'hC0, 0);
        step("acq3", 1, 'hE0, 0);
        chk("acq.locked_const", 32'(locked), 32'd1);
        chk("acq.index_const", 32'(index), 32'd3);

        for (int k = 4; k < R; k++) step("ring", 1, ring[k], 0);
        step("ring.wrap", 1, 'h00, 0);
        chk("ring.wrap_const", 32'(wrap_cnt), 32'd1);
        for (int i = 0; i < 3; i++) step("hold", 1, 'h80, 0);
        chk("hold.locked_const", 32'(locked), 32'd1);

        step("illegal", 1, 'hA5, 0);
        chk("illegal.index_hold", 32'(index), 32'd1);
        chk("illegal.code_err_const", 32'(code_err), 32'd1);
        step("relock0", 1, 'hC0, 0);
        step("relock1", 1, 'hE0, 0);
        step("relock2", 1, 'hF0, 0);
        step("relock3", 1, 'hF8, 0);
        step("clr", 0, 0, 1);

        step("jump0", 1, 'h00, 0);
        step("seq1", 1, 'h80, 0);
        step("seq2", 1, 'hC0, 0);
        step("seqerr", 1, 'hF0, 0);
        chk("seqerr.const", 32'({seq_err, locked, index}), 32'({1'b1, 1'b0, 4'd4}));
        step("re5", 1, 'hF8, 0);
        step("re6", 1, 'hFC, 0);
        step("re7", 1, 'hFE, 0);
        step("src_reset", 1, 'h00, 0);
        chk("src_reset.locked_const", 32'(locked), 32'd1);
        step("clr_pri", 1, 'h18, 1);
        chk("clr_pri.code_err_const", 32'(code_err), 32'd1);

        step("pre_rst0", 1, 'h00, 0);
        step("pre_rst1", 1, 'h80, 0);
        step("pre_rst2", 1, 'hC0, 0);
        step("pre_rst3", 1, 'hE0, 0);
        in_valid = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        step("post_rst", 0, 0, 0);

        cur = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            int c;
            bit v;
            r = $urandom_range(0, 99);
            v = 1'b1;
            if (r < 8) begin
                v = 1'b0;
                c = int'($urandom_range(0, 255));
            end else if (r < 14) begin
                c = int'($urandom_range(0, 255));
            end else if (r < 22) begin
                cur = $urandom_range(0, R - 1);
                c = ring[cur];
            end else if (r < 30) begin
                c = ring[cur];
            end else begin
                cur = (cur + 1) % R;
                c = ring[cur];
            end
            step("rnd", v, c, ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
